// File: rtl/fifo_drain.sv
// fifo_drain: drains a registered-read upstream FIFO into a valid/ready stream.
// Optional feature: define FIFO_DRAIN_CNT_EN to add the 16-bit drain_cnt output.
module fifo_drain #(
    parameter int width = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             flush,
    input  logic             fifo_empty,
    input  logic [width-1:0] fifo_out,
    output logic             fifo_pop,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [width-1:0] m_data,
`ifdef FIFO_DRAIN_CNT_EN
    output logic [15:0]      drain_cnt,
`endif
    output logic             busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_n;
    logic [1:0]       occ;
    logic [1:0]       rptr;
    logic [1:0]       wptr;
    logic             infl;
    logic             cap;
    logic             xfer;
    logic             room;
    logic [width-1:0] mem [0:2];

    function automatic logic [1:0] inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Pop only when the in-flight word is guaranteed a free slot on landing.
    always_comb begin
        room     = ({1'b0, occ} + {2'b0, infl}) < 3'd3;
        fifo_pop = en & ~fifo_empty & ~flush & (state == RUN) & room;
        cap      = infl & ~flush & (state != FLUSH);
        m_valid  = (occ != 2'd0);
        xfer     = m_valid & m_ready;
        m_data   = m_valid ? mem[rptr] : '0;
        busy     = m_valid | infl;
    end

    // Next-state logic; flush overrides everything.
    always_comb begin
        state_n = state;
        if (flush) begin
            state_n = infl ? FLUSH : IDLE;
        end else begin
            case (state)
                IDLE:    if (en) state_n = RUN;
                RUN:     if (!en && occ == 2'd0 && !infl) state_n = IDLE;
                FLUSH:   state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // State, in-flight flag, pointers and occupancy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            infl  <= 1'b0;
            occ   <= 2'd0;
            rptr  <= 2'd0;
            wptr  <= 2'd0;
        end else begin
            state <= state_n;
            infl  <= fifo_pop;
            if (flush) begin
                occ  <= 2'd0;
                rptr <= 2'd0;
                wptr <= 2'd0;
            end else begin
                if (cap)  wptr <= inc(wptr);
                if (xfer) rptr <= inc(rptr);
                occ <= occ + {1'b0, cap} - {1'b0, xfer};
            end
        end
    end

    // Landing word capture into the circular buffer.
    always_ff @(posedge clk) begin
        if (cap) mem[wptr] <= fifo_out;
    end

`ifdef FIFO_DRAIN_CNT_EN
    // Downstream transfer counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)      drain_cnt <= 16'd0;
        else if (flush) drain_cnt <= 16'd0;
        else if (xfer)  drain_cnt <= drain_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain: directed stimulus with a scoreboard queue and a
// separate output monitor for fifo_drain.
module tb_fifo_drain;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         en = 1'b0;
    logic         flush = 1'b0;
    logic         m_ready = 1'b0;
    logic         fifo_empty;
    logic         fifo_pop;
    logic         m_valid;
    logic         busy;
    logic [W-1:0] fifo_out = '0;
    logic [W-1:0] m_data;
`ifdef FIFO_DRAIN_CNT_EN
    logic [15:0]  drain_cnt;
`endif

    int total = 0;
    int bad = 0;
    int head = 0;
    int tail = 0;
    int pops = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] umem [0:131071];

    fifo_drain #(.width(W)) dut (
        .clk(clk),
        .rstn(rstn),
        .en(en),
        .flush(flush),
        .fifo_empty(fifo_empty),
        .fifo_out(fifo_out),
        .fifo_pop(fifo_pop),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
`ifdef FIFO_DRAIN_CNT_EN
        .drain_cnt(drain_cnt),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Upstream FIFO with registered read data.
    assign fifo_empty = (head == tail);
    always @(posedge clk) begin
        if (fifo_pop) begin
            fifo_out <= umem[head];
            head     <= head + 1;
            pops     <= pops + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic up(input logic [W-1:0] w, input bit keep);
        umem[tail] = w;
        tail++;
        if (keep) exp_q.push_back(w);
    endtask

    task automatic drain(input string name, input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            cyc();
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    // Monitor: every downstream transfer must match the scoreboard head.
    always @(negedge clk) begin
        if (rstn && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_word: got %0h want none", m_data);
            end else begin
                chk("m_data", m_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       e_pop [7] = '{0, 1, 1, 1, 0, 0, 0};
        logic       e_val [7] = '{0, 0, 0, 1, 1, 1, 0};
        logic       e_bsy [7] = '{0, 0, 1, 1, 1, 1, 0};
        logic [3:0] wv [10] = '{4'h1, 4'h4, 4'h7, 4'hA, 4'hD,
                                4'h0, 4'h3, 4'h6, 4'h9, 4'hC};
        int p0;
        int n;

        // Reset state
        repeat (2) @(posedge clk);
        smp();
        chk("rst_valid", m_valid, 0);
        chk("rst_pop", fifo_pop, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", m_data, 0);
        cyc();
        rstn = 1'b1;

        // Basic: 3,5,9 with en raised in cycle 0
        cyc();
        up(4'h3, 1);
        up(4'h5, 1);
        up(4'h9, 1);
        en = 1'b1;
        m_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) cyc();
            smp();
            chk($sformatf("basic_pop_c%0d", c), fifo_pop, e_pop[c]);
            chk($sformatf("basic_valid_c%0d", c), m_valid, e_val[c]);
            chk($sformatf("basic_busy_c%0d", c), busy, e_bsy[c]);
            if (c == 3) chk("basic_first", m_data, 4'h3);
        end
        chk("basic_left", exp_q.size(), 0);

        // Backpressure: 5 words, sink stalled
        cyc();
        m_ready = 1'b0;
        p0 = pops;
        up(4'hA, 1);
        up(4'hB, 1);
        up(4'hC, 1);
        up(4'hD, 1);
        up(4'hE, 1);
        for (int c = 0; c < 8; c++) begin
            if (c > 0) cyc();
            smp();
            if (c >= 3) begin
                chk($sformatf("bp_valid_c%0d", c), m_valid, 1);
                chk($sformatf("bp_hold_c%0d", c), m_data, 4'hA);
            end
        end
        chk("bp_pops", pops - p0, 3);
        chk("bp_busy", busy, 1);
        cyc();
        m_ready = 1'b1;
        drain("bp_drain", 40);
        chk("bp_upstream_empty", fifo_empty, 1);

        // Wrap: 10 words, sink ready toggling
        cyc();
        for (int i = 0; i < 10; i++) up(wv[i], 1);
        n = 0;
        while (exp_q.size() != 0 && n < 80) begin
            cyc();
            m_ready = ~m_ready;
            n++;
        end
        chk("wrap_drain", exp_q.size(), 0);
        cyc();
        m_ready = 1'b1;
        smp();
        chk("wrap_idle_busy", busy, 0);

        // Flush with a word in flight
        cyc();
        up(4'h6, 0);
        smp();
        chk("fl_pop_t0", fifo_pop, 1);
        cyc();
        flush = 1'b1;
        up(4'h7, 1);
        smp();
        chk("fl_busy_t1", busy, 1);
        chk("fl_pop_t1", fifo_pop, 0);
        cyc();
        flush = 1'b0;
        smp();
        chk("fl_pop_t2", fifo_pop, 0);
        chk("fl_valid_t2", m_valid, 0);
        chk("fl_busy_t2", busy, 0);
        cyc();
        smp();
        chk("fl_pop_t3", fifo_pop, 0);
        chk("fl_valid_t3", m_valid, 0);
        cyc();
        smp();
        chk("fl_pop_t4", fifo_pop, 1);
        drain("fl_drain", 20);

        // Reset mid-stream with two words buffered
        cyc();
        m_ready = 1'b0;
        up(4'hB, 0);
        up(4'hC, 0);
        cyc();
        cyc();
        cyc();
        up(4'hE, 0);
        smp();
        chk("rs_pre_valid", m_valid, 1);
        chk("rs_pre_data", m_data, 4'hB);
        chk("rs_pre_pop", fifo_pop, 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("rs_valid", m_valid, 0);
        chk("rs_pop", fifo_pop, 0);
        chk("rs_busy", busy, 0);
        chk("rs_data", m_data, 0);
        cyc();
        cyc();
        rstn = 1'b1;
        exp_q.push_back(4'hE);
        m_ready = 1'b1;
        drain("rs_drain", 20);
        cyc();
        smp();
        chk("rs_idle_valid", m_valid, 0);

`ifdef FIFO_DRAIN_CNT_EN
        // Counter: 1 + 0x10000 transfers wraps back to 1, flush clears
        chk("cnt_start", drain_cnt, 16'd1);
        cyc();
        for (int i = 0; i < 65536; i++) up(i[3:0], 1);
        drain("cnt_drain", 70000);
        cyc();
        cyc();
        smp();
        chk("cnt_wrap", drain_cnt, 16'd1);
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        smp();
        chk("cnt_flush", drain_cnt, 16'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
